// File: rtl/seq_div_6b3b.sv
// rtl/seq_div_6b3b.sv - sequential restoring divider, 6-bit dividend by 3-bit divisor
//
// Resolves one quotient bit per clock, MSB first, under a start/busy/done
// handshake. A zero divisor skips the iteration and reports div_by_zero.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset (overrides start, aborts a division)
//   start_i        request, sampled only while busy_o is low
//   dividend_i     numerator, captured on an accepted start
//   divisor_i      denominator, captured on an accepted start
//   quotient_o     registered quotient, held until the next result or reset
//   remainder_o    registered remainder, held until the next result or reset
//   busy_o         high while a division is in progress (CALC and FIN)
//   done_o         one-cycle pulse, results valid
//   div_by_zero_o  set with done when the captured divisor was zero, held with results

module seq_div_6b3b #(
  parameter int DW = 6,
  parameter int VW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic [DW-1:0] quotient_o,
  output logic [VW-1:0] remainder_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          div_by_zero_o
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dq_q, dq_d;         // dividend shifting out, quotient shifting in
  // Only the low VW bits of the partial remainder are stored: after the
  // restoring step it is always below the divisor, so the extra bit is only
  // needed for the shifted value that feeds the compare.
  logic [VW-1:0] pr_q, pr_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;         // divide-by-zero pending for FIN
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;

  logic [VW:0]   pr_shift;
  logic [VW:0]   pr_sub;
  logic          fits;

  assign pr_shift = {pr_q, dq_q[DW-1]};
  assign pr_sub   = pr_shift - {1'b0, dvs_q};
  assign fits     = (pr_shift >= {1'b0, dvs_q});

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    pr_d    = pr_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dq_d  = dividend_i;
          dvs_d = divisor_i;
          pr_d  = '0;
          cnt_d = CW'(DW);
          if (divisor_i == '0) begin
            dz_d    = 1'b1;
            state_d = S_FIN;
          end else begin
            dz_d    = 1'b0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (fits) begin
          pr_d = pr_sub[VW-1:0];
          dq_d = {dq_q[DW-2:0], 1'b1};
        end else begin
          pr_d = pr_shift[VW-1:0];
          dq_d = {dq_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        quot_d  = dz_q ? '1 : dq_q;
        rem_d   = dz_q ? '0 : pr_q;
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      dq_q    <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      pr_q    <= pr_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;
  assign done_o        = done_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_div_6b3b.sv
// tb/tb_seq_div_6b3b.sv - self-checking bench for seq_div_6b3b
module tb_seq_div_6b3b;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [5:0] dividend_i;
  logic [2:0] divisor_i;
  logic [5:0] quotient_o;
  logic [2:0] remainder_o;
  logic       busy_o;
  logic       done_o;
  logic       div_by_zero_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_div_6b3b dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: plain integer division, with the zero-divisor convention.
  task automatic model(input int a, input int b, output int q, output int r,
                       output int dz, output int lat);
    if (b == 0) begin
      q = 63; r = 0; dz = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = 7;
    end
  endtask

  // Called #1 after an edge with busy low; returns #1 after the accepting edge.
  task automatic start_op(input int a, input int b);
    start_i    = 1'b1;
    dividend_i = 6'(a);
    divisor_i  = 3'(b);
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    dividend_i = 6'($urandom);
    divisor_i  = 3'($urandom);
    chk("busy_after_accept", int'(busy_o), 1);
    chk("done_low_after_accept", int'(done_o), 0);
  endtask

  task automatic wait_done(input int e0, output int edges);
    edges = e0;
    do begin
      @(posedge clk_i); #1;
      edges++;
    end while (!done_o && edges < 30);
    if (!done_o) chk("done_timeout", edges, -1);
  endtask

  task automatic check_result(input string tag, input int a, input int b, input int edges);
    int q, r, dz, lat;
    model(a, b, q, r, dz, lat);
    chk({tag, "_lat"}, edges, lat);
    chk({tag, "_q"}, int'(quotient_o), q);
    chk({tag, "_r"}, int'(remainder_o), r);
    chk({tag, "_dz"}, int'(div_by_zero_o), dz);
    chk({tag, "_busy_at_done"}, int'(busy_o), 0);
    if (b != 0) chk({tag, "_recompose"}, int'(quotient_o) * b + int'(remainder_o), a);
  endtask

  initial begin
    int e, cnt, last_q, q, r, dz, lat;
    rst_i = 1'b1; start_i = 1'b1; dividend_i = 6'd45; divisor_i = 3'd5;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_q", int'(quotient_o), 0);
    chk("rst_r", int'(remainder_o), 0);
    chk("rst_dz", int'(div_by_zero_o), 0);
    rst_i = 1'b0; start_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed vectors.
    tbl[0] = '{45, 5, 9, 0, 0};
    tbl[1] = '{50, 7, 7, 1, 0};
    tbl[2] = '{5, 7, 0, 5, 0};
    tbl[3] = '{63, 1, 63, 0, 0};
    tbl[4] = '{17, 0, 63, 0, 1};
    tbl[5] = '{63, 3, 21, 0, 0};
    tbl[6] = '{0, 6, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      start_op(tbl[i].a, tbl[i].b);
      wait_done(0, e);
      chk("tbl_lat", e, (tbl[i].b == 0) ? 1 : 7);
      chk("tbl_q", int'(quotient_o), tbl[i].q);
      chk("tbl_r", int'(remainder_o), tbl[i].r);
      chk("tbl_dz", int'(div_by_zero_o), tbl[i].dz);
      chk("tbl_busy_at_done", int'(busy_o), 0);
      @(posedge clk_i); #1;
      chk("tbl_done_one_cycle", int'(done_o), 0);
      chk("tbl_q_hold", int'(quotient_o), tbl[i].q);
    end

    // Start while busy is ignored: 40/3 with a 9/2 request on cycle 3.
    start_op(40, 3);
    repeat (2) @(posedge clk_i);
    #1;
    start_i = 1'b1; dividend_i = 6'd9; divisor_i = 3'd2;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(3, e);
    chk("busy_ign_lat", e, 7);
    chk("busy_ign_q", int'(quotient_o), 13);
    chk("busy_ign_r", int'(remainder_o), 1);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_i); #1;
      if (done_o) cnt++;
    end
    chk("busy_ign_extra_done", cnt, 0);

    // Reset mid-operation aborts without a done pulse.
    start_op(60, 7);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_q", int'(quotient_o), 0);
    chk("abort_r", int'(remainder_o), 0);
    chk("abort_dz", int'(div_by_zero_o), 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_i); #1;
      if (done_o) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    start_op(60, 7);
    wait_done(0, e);
    check_result("after_abort", 60, 7, e);
    @(posedge clk_i); #1;

    // Exhaustive, back-to-back: each next start lands in the done cycle.
    start_op(0, 0);
    for (int i = 0; i < 512; i++) begin
      wait_done(0, e);
      check_result("exh", i >> 3, i & 7, e);
      if (i < 511) start_op((i + 1) >> 3, (i + 1) & 7);
    end
    @(posedge clk_i); #1;

    // Randomized: idle gaps, spurious starts while busy, held results.
    last_q = int'(quotient_o);
    for (int n = 0; n < 150; n++) begin
      int a, b, g;
      a = $urandom_range(0, 63);
      b = $urandom_range(0, 7);
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) begin
        @(posedge clk_i); #1;
      end
      chk("rnd_q_hold", int'(quotient_o), last_q);
      start_op(a, b);
      e = 0;
      if (b != 0 && $urandom_range(0, 1) == 1) begin
        @(posedge clk_i); #1;
        start_i = 1'b1; dividend_i = 6'($urandom); divisor_i = 3'($urandom);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        e = 2;
      end
      wait_done(e, e);
      check_result("rnd", a, b, e);
      model(a, b, q, r, dz, lat);
      last_q = q;
      @(posedge clk_i); #1;
      chk("rnd_done_one_cycle", int'(done_o), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_div_6b3b.md
Name: seq_div_6b3b

Overview:
- Sequential restoring divider: 6-bit dividend ÷ 3-bit divisor, producing a 6-bit quotient and a 3-bit remainder.
- It is the inverse companion to the 3x3 array multiplier. Multiplier products feed this block, and this block's results recompose through the multiplier for self-check.
- It resolves one quotient bit per clock, MSB first, under a start/busy/done handshake.
- It is a shared arithmetic utility for datapath blocks that cannot afford a combinational divider.

Parameters:
- DW, 6, dividend and quotient width.
- VW, 3, divisor and remainder width. Internal partial remainder is VW+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request. Sampled only when busy=0.
- dividend  input  DW  numerator. Captured on accepted start.
- divisor  input  VW  denominator. Captured on accepted start.
- quotient  output  DW  result quotient. Registered.
- remainder  output  VW  result remainder. Registered.
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse: results valid
- div_by_zero  output  1  set with done when the captured divisor is 0. Held with the results.

Behaviour:
- Reset: on a rising edge with rst=1, all outputs are driven to 0, state goes to IDLE, and internal registers are cleared. rst overrides start. rst mid-operation aborts the division; no done pulse is produced for it.
- States:
  - IDLE: busy=0. On start=1, capture dividend into the shift register, capture divisor, clear the partial remainder, and load the iteration counter with DW.
    - If the divisor is nonzero, go to CALC.
    - If the divisor is 0, go to FIN with div_by_zero pending.
  - CALC: busy=1. Each cycle:
    - pr = {pr[VW-1:0], dq[DW-1]}; shift dq left.
    - If pr >= divisor, then pr -= divisor and the new dq LSB = 1; otherwise the LSB = 0.
    - Decrement the counter. After the DW-th iteration, go to FIN.
  - FIN: single cycle.
    - Register quotient = dq and remainder = pr[VW-1:0]. Assert done=1. Go to IDLE.
    - busy=1 in FIN, so a start in that cycle is ignored.
    - Divide-by-zero case: quotient = all ones (6'h3F), remainder = 0, div_by_zero = 1.
- Latency:
  - Start accepted on edge E0. CALC occupies edges E1..E6. FIN registers results on edge E7.
  - done is high during the cycle after E7, exactly 1 cycle. busy is high from after E0 until after E7.
  - Divide-by-zero: FIN occurs on edge E1. done is high during the cycle after E1.
  - Next start is accepted in the same cycle done is high, since busy=0 by then. Back-to-back throughput is one division per DW+2 cycles.
- start while busy=1 is ignored. Captured operands are not disturbed.
- Operand inputs may change freely after acceptance.
- quotient, remainder and div_by_zero hold their values until the next FIN or reset. They are not cleared on a new start.
- div_by_zero is cleared at the FIN of a nonzero-divisor division.
- Arithmetic rules:
  - Unsigned only.
  - Quotient never overflows DW because divisor >= 1.
  - remainder < divisor always holds. Check: quotient*divisor + remainder == dividend.
  - The pr compare and subtract use VW+1 bits. pr never exceeds 2*divisor-1 before the subtract.

Test Plan:
- Reset, then 45/5 -> exactly 8 cycles after start edge: done=1, quotient=9, remainder=0, div_by_zero=0. busy low the cycle done rises.
- 50/7 -> quotient=7, remainder=1. 5/7 -> quotient=0, remainder=5. 63/1 -> quotient=63, remainder=0.
- 17/0 -> 2 cycles after start: done=1, div_by_zero=1, quotient=6'h3F, remainder=0. Following 63/3 -> quotient=21, remainder=0, div_by_zero=0.
- Start 40/3, pulse start again with 9/2 on cycle 3 -> second request ignored; result quotient=13, remainder=1, single done pulse.
- Start 60/7, assert rst on cycle 4 -> all outputs 0 next cycle, no done. Then 60/7 -> quotient=8, remainder=4.
- Exhaustive: all 64x8 operand pairs issued back-to-back with start in each done cycle. Compare against integer / and %. Check quotient*divisor+remainder == dividend via the 3x3 multiplier for quotient < 8.
